// File: rtl/grn_node_lut_if.sv
// Signal bundle between the GRN network controller and one grn_node_lut.
// Knockout ports exist only when GRN_NODE_KNOCKOUT_EN is defined.
interface grn_node_lut_if #(
  parameter int NUM_IN = 4,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
);
  logic                    cfg_we;
  logic [NUM_IN-1:0]       cfg_addr;
  logic                    cfg_bit;
  logic                    reset_nos;
  logic [LANES-1:0]        init_state;
  logic                    start_s0;
  logic                    start_s1;
  logic [LANES*NUM_IN-1:0] in_s0;
  logic [LANES*NUM_IN-1:0] in_s1;
  logic [LANES-1:0]        s0;
  logic [LANES-1:0]        s1;
  logic [LANES-1:0]        match;
  logic [CNT_W-1:0]        fast_steps;
`ifdef GRN_NODE_KNOCKOUT_EN
  logic [LANES-1:0]        ko_en;
  logic [LANES-1:0]        ko_val;
`endif

  modport master (
    output cfg_we, cfg_addr, cfg_bit, reset_nos, init_state,
           start_s0, start_s1, in_s0, in_s1,
`ifdef GRN_NODE_KNOCKOUT_EN
    output ko_en, ko_val,
`endif
    input  s0, s1, match, fast_steps
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_bit, reset_nos, init_state,
           start_s0, start_s1, in_s0, in_s1,
`ifdef GRN_NODE_KNOCKOUT_EN
    input  ko_en, ko_val,
`endif
    output s0, s1, match, fast_steps
  );
endinterface

// File: rtl/grn_node_lut.sv
// GRN node: programmable truth-table rule, slow/fast trajectory copies per lane.
// Optional knockout override enabled by defining GRN_NODE_KNOCKOUT_EN.
module grn_node_lut #(
  parameter int NUM_IN   = 4,
  parameter int LANES    = 4,
  parameter int SLOW_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  grn_node_lut_if.slave   bus
);

  localparam int DEPTH = 1 << NUM_IN;
  localparam int PH_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOW_DIV - 1);

  logic [DEPTH-1:0] lut;
  logic [LANES-1:0] s0_q, s1_q;
  logic [LANES-1:0] next_s0, next_s1;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] fast_steps_q;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    next_s0 = '0;
    next_s1 = '0;
    for (int l = 0; l < LANES; l++) begin
      next_s0[l] = lut[bus.in_s0[l*NUM_IN +: NUM_IN]];
      next_s1[l] = lut[bus.in_s1[l*NUM_IN +: NUM_IN]];
`ifdef GRN_NODE_KNOCKOUT_EN
      if (bus.ko_en[l]) begin
        next_s0[l] = bus.ko_val[l];
        next_s1[l] = bus.ko_val[l];
      end
`endif
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
  // this is also what makes a same-cycle evaluation see the old LUT contents.
  // NOTE: the LUT is a small flop array, not a RAM, so it can and must clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut          <= '0;
      s0_q         <= '0;
      s1_q         <= '0;
      phase        <= '0;
      fast_steps_q <= '0;
    end else begin
      if (bus.cfg_we) lut[bus.cfg_addr] <= bus.cfg_bit;

      if (bus.reset_nos) begin
        s0_q         <= bus.init_state;
        s1_q         <= bus.init_state;
        phase        <= '0;
        fast_steps_q <= '0;
      end else begin
        if (bus.start_s0) begin
          if (phase == '0) s0_q <= next_s0;
          phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
        if (bus.start_s1) begin
          s1_q <= next_s1;
          if (fast_steps_q != '1) fast_steps_q <= fast_steps_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.s0         = s0_q;
  assign bus.s1         = s1_q;
  assign bus.match      = ~(s0_q ^ s1_q);
  assign bus.fast_steps = fast_steps_q;

endmodule

// File: tb/tb_grn_node_lut.sv
// Directed self-checking bench for grn_node_lut (NUM_IN=2, LANES=4, SLOW_DIV=2, CNT_W=4).
// Define GRN_NODE_KNOCKOUT_EN to also exercise the knockout override.
module tb_grn_node_lut;
  localparam int NUM_IN = 2, LANES = 4, SLOW_DIV = 2, CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  grn_node_lut_if #(.NUM_IN(NUM_IN), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  grn_node_lut #(.NUM_IN(NUM_IN), .LANES(LANES), .SLOW_DIV(SLOW_DIV), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; one rising edge; outputs read on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    bus.reset_nos = 1'b0;
    bus.start_s0  = 1'b0;
    bus.start_s1  = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic prog_lut(input logic [3:0] v);
    for (int a = 0; a < 4; a++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'(a);
      bus.cfg_bit  = v[a];
      step();
    end
  endtask

  task automatic load(input logic [3:0] init);
    bus.init_state = init;
    bus.reset_nos  = 1'b1;
    step();
  endtask

  task automatic pulse(input logic p0, input logic p1, input logic [7:0] i0, input logic [7:0] i1);
    bus.in_s0    = i0;
    bus.in_s1    = i1;
    bus.start_s0 = p0;
    bus.start_s1 = p1;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_bit = 1'b0;
    bus.reset_nos = 1'b0; bus.init_state = '0;
    bus.start_s0 = 1'b0; bus.start_s1 = 1'b0;
    bus.in_s0 = '0; bus.in_s1 = '0;
`ifdef GRN_NODE_KNOCKOUT_EN
    bus.ko_en = '0; bus.ko_val = '0;
`endif
    @(negedge clk);
    rst = 1'b1;
    step();

    // Reset state
    check("rst_s0", 32'(bus.s0), 32'h0);
    check("rst_s1", 32'(bus.s1), 32'h0);
    check("rst_match", 32'(bus.match), 32'hF);
    check("rst_steps", 32'(bus.fast_steps), 32'h0);

    // Test 1: AND rule, fast step with mixed lane inputs
    prog_lut(4'b1000);
    load(4'b0110);
    check("load_s0", 32'(bus.s0), 32'h6);
    check("load_s1", 32'(bus.s1), 32'h6);
    load(4'b0000);
    pulse(1'b0, 1'b1, 8'h00, 8'b11_10_01_11);
    check("t1_s1", 32'(bus.s1), 32'h9);
    check("t1_s0", 32'(bus.s0), 32'h0);
    check("t1_match", 32'(bus.match), 32'h6);
    check("t1_steps", 32'(bus.fast_steps), 32'h1);

    // Idle cycles: all state holds
    bus.in_s0 = 8'hFF; bus.in_s1 = 8'h00;
    step(); step(); step();
    check("hold_s1", 32'(bus.s1), 32'h9);
    check("hold_steps", 32'(bus.fast_steps), 32'h1);

    // Test 2: slow copy updates only at phase 0 (phase 1,0,1,0,...)
    load(4'b0000);
    pulse(1'b1, 1'b0, 8'hFF, 8'h00);
    check("t2_p1_s0", 32'(bus.s0), 32'hF);
    check("t2_p1_s1", 32'(bus.s1), 32'h0);
    pulse(1'b1, 1'b0, 8'h00, 8'h00);
    check("t2_p2_hold", 32'(bus.s0), 32'hF);
    pulse(1'b1, 1'b0, 8'h00, 8'h00);
    check("t2_p3_upd", 32'(bus.s0), 32'h0);
    pulse(1'b1, 1'b0, 8'hFF, 8'h00);
    check("t2_p4_hold", 32'(bus.s0), 32'h0);
    pulse(1'b1, 1'b0, 8'hFF, 8'h00);
    check("t2_p5_upd", 32'(bus.s0), 32'hF);
    check("t2_steps", 32'(bus.fast_steps), 32'h0);

    // Coincident slow and fast steps from independent inputs
    load(4'b0000);
    pulse(1'b1, 1'b1, 8'hFF, 8'b11_00_11_00);
    check("co_s0", 32'(bus.s0), 32'hF);
    check("co_s1", 32'(bus.s1), 32'hA);
    check("co_match", 32'(bus.match), 32'hA);
    check("co_steps", 32'(bus.fast_steps), 32'h1);

    // Test 3: LUT write in the same cycle as an evaluation uses the old entry
    load(4'b0000);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_bit = 1'b0;
    pulse(1'b0, 1'b1, 8'h00, 8'hFF);
    check("t3_old_lut", 32'(bus.s1), 32'hF);
    pulse(1'b0, 1'b1, 8'h00, 8'hFF);
    check("t3_new_lut", 32'(bus.s1), 32'h0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_bit = 1'b1;
    step();

    // Test 4: counter saturates at 15, reset_nos clears it and wins over start_s1
    load(4'b0000);
    bus.in_s1 = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      bus.start_s1 = 1'b1;
      step();
      if (i == 13) check("t4_steps14", 32'(bus.fast_steps), 32'd14);
    end
    check("t4_sat", 32'(bus.fast_steps), 32'd15);
    check("t4_s1", 32'(bus.s1), 32'hF);
    bus.start_s1 = 1'b1;
    load(4'b0101);
    check("t4_clr_steps", 32'(bus.fast_steps), 32'd0);
    check("t4_clr_s0", 32'(bus.s0), 32'h5);
    check("t4_clr_s1", 32'(bus.s1), 32'h5);

    // Test 5: rst mid-run clears state and LUT
    pulse(1'b1, 1'b1, 8'hFF, 8'hFF);
    pulse(1'b1, 1'b1, 8'hFF, 8'hFF);
    pulse(1'b1, 1'b1, 8'hFF, 8'hFF);
    check("t5_pre_steps", 32'(bus.fast_steps), 32'd3);
    rst = 1'b1;
    bus.start_s1 = 1'b1; bus.reset_nos = 1'b1; bus.init_state = 4'hF;
    step();
    check("t5_s0", 32'(bus.s0), 32'h0);
    check("t5_s1", 32'(bus.s1), 32'h0);
    check("t5_steps", 32'(bus.fast_steps), 32'd0);
    check("t5_match", 32'(bus.match), 32'hF);
    load(4'b1111);
    pulse(1'b0, 1'b1, 8'h00, 8'hFF);
    check("t5_lut_clr", 32'(bus.s1), 32'h0);

`ifdef GRN_NODE_KNOCKOUT_EN
    // Test 6: knockout forces lane 2 regardless of the rule
    prog_lut(4'b1000);
    load(4'b0000);
    bus.ko_en = 4'b0100; bus.ko_val = 4'b0100;
    pulse(1'b1, 1'b1, 8'h00, 8'h00);
    check("t6_s0", 32'(bus.s0), 32'h4);
    check("t6_s1", 32'(bus.s1), 32'h4);
    bus.ko_en = 4'b0100; bus.ko_val = 4'b1111;
    load(4'b0000);
    check("t6_load", 32'(bus.s1), 32'h0);
    bus.ko_en = '0; bus.ko_val = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
